// File: rtl/prga_decrypt_fsm.sv
// prga_decrypt_fsm: RC4 pseudo-random generation and decrypt stage.
// Walks i/j over the S RAM left by the key-schedule shuffle, swaps S[i]/S[j],
// fetches the keystream byte S[S[i]+S[j]] and writes keystream XOR ciphertext
// to the decrypted-message RAM, one byte per pass of the loop.
// Optional feature macro: CHAR_CHECK_EN (reject plaintext outside a-z / space).
module prga_decrypt_fsm #(
    parameter int unsigned MSG_LEN = 32,
    parameter int unsigned RD_LAT  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic [7:0] s_q,
    output logic [7:0] s_address,
    output logic [7:0] s_data,
    output logic       s_wren,
    output logic       s_rden,
    output logic [7:0] msg_address,
    input  logic [7:0] msg_q,
    output logic [7:0] dec_address,
    output logic [7:0] dec_data,
    output logic       dec_wren,
    output logic       busy,
    output logic       done,
    output logic       fail
);

    localparam int unsigned WAIT_W    = 8;
    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(RD_LAT - 1);
    localparam logic [7:0]        K_LAST    = 8'(MSG_LEN - 1);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_INC_I  = 4'd1,
        S_RD_SI  = 4'd2,
        S_CAP_SI = 4'd3,
        S_RD_SJ  = 4'd4,
        S_CAP_SJ = 4'd5,
        S_WR_SI  = 4'd6,
        S_WR_SJ  = 4'd7,
        S_RD_F   = 4'd8,
        S_CAP_F  = 4'd9,
        S_WR_DEC = 4'd10,
        S_NEXT   = 4'd11,
        S_DONE   = 4'd12
`ifdef CHAR_CHECK_EN
        ,
        S_FAIL   = 4'd13
`endif
    } state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;

    logic [7:0] i_q, i_d, j_q, j_d, k_q, k_d;
    logic [7:0] si_q, si_d, sj_q, sj_d, f_q, f_d, enc_q, enc_d;
    logic       stop_pend_q, stop_pend_d;

    logic [7:0] s_address_q, s_address_d, s_data_q, s_data_d;
    logic       s_wren_q, s_wren_d, s_rden_q, s_rden_d;
    logic [7:0] msg_address_q, msg_address_d;
    logic [7:0] dec_address_q, dec_address_d, dec_data_q, dec_data_d;
    logic       dec_wren_q, dec_wren_d;
    logic       busy_q, busy_d, done_q, done_d, fail_q, fail_d;

`ifdef CHAR_CHECK_EN
    // Plaintext is accepted only as lowercase letters or space
    function automatic logic char_ok(input logic [7:0] c);
        return (c == 8'h20) || ((c >= 8'h61) && (c <= 8'h7A));
    endfunction
`endif

    // State and read-latency counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Next-state logic; every read state dwells RD_LAT clocks
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_INC_I;
            S_INC_I: begin
                state_d = S_RD_SI;
                wait_d  = WAIT_INIT;
            end
            S_RD_SI: begin
                if (wait_q == '0) state_d = S_CAP_SI;
                else              wait_d  = wait_q - WAIT_W'(1);
            end
            S_CAP_SI: begin
                state_d = S_RD_SJ;
                wait_d  = WAIT_INIT;
            end
            S_RD_SJ: begin
                if (wait_q == '0) state_d = S_CAP_SJ;
                else              wait_d  = wait_q - WAIT_W'(1);
            end
            S_CAP_SJ: state_d = S_WR_SI;
            S_WR_SI:  state_d = S_WR_SJ;
            S_WR_SJ: begin
                state_d = S_RD_F;
                wait_d  = WAIT_INIT;
            end
            S_RD_F: begin
                if (wait_q == '0) state_d = S_CAP_F;
                else              wait_d  = wait_q - WAIT_W'(1);
            end
            S_CAP_F:  state_d = S_WR_DEC;
`ifdef CHAR_CHECK_EN
            S_WR_DEC: state_d = char_ok(dec_data_q) ? S_NEXT : S_FAIL;
            S_FAIL:   if (start) state_d = S_INC_I;
`else
            S_WR_DEC: state_d = S_NEXT;
`endif
            S_NEXT: begin
                if (stop || stop_pend_q) state_d = S_IDLE;
                else if (k_q == K_LAST)  state_d = S_DONE;
                else                     state_d = S_INC_I;
            end
            S_DONE:   if (start) state_d = S_INC_I;
            default:  state_d = S_IDLE;
        endcase
    end

    // Datapath updates for the current state, then registered outputs for the state being entered
    always_comb begin
        i_d           = i_q;
        j_d           = j_q;
        k_d           = k_q;
        si_d          = si_q;
        sj_d          = sj_q;
        f_d           = f_q;
        enc_d         = enc_q;
        stop_pend_d   = stop_pend_q;
        s_address_d   = s_address_q;
        s_data_d      = s_data_q;
        s_wren_d      = 1'b0;
        s_rden_d      = 1'b1;
        msg_address_d = msg_address_q;
        dec_address_d = dec_address_q;
        dec_data_d    = dec_data_q;
        dec_wren_d    = 1'b0;
        busy_d        = 1'b1;
        done_d        = 1'b0;
        fail_d        = 1'b0;

        case (state_q)
            S_INC_I:  i_d = i_q + 8'd1;
            S_CAP_SI: begin
                si_d = s_q;
                j_d  = j_q + s_q;
            end
            S_CAP_SJ: sj_d = s_q;
            S_CAP_F: begin
                f_d   = s_q;
                enc_d = msg_q;
            end
            S_NEXT: begin
                if (!(stop || stop_pend_q) && (k_q != K_LAST)) k_d = k_q + 8'd1;
            end
            default: ;
        endcase

        // A stop seen mid-byte is remembered until the byte completes
        if (busy_q && stop) stop_pend_d = 1'b1;
        if (state_d == S_IDLE) stop_pend_d = 1'b0;

        // Accepted start begins a fresh message with i = j = k = 0
        if (start && !busy_q && (state_d == S_INC_I)) begin
            i_d         = 8'd0;
            j_d         = 8'd0;
            k_d         = 8'd0;
            stop_pend_d = 1'b0;
        end

        case (state_d)
            S_IDLE: busy_d = 1'b0;
            S_DONE: begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
`ifdef CHAR_CHECK_EN
            S_FAIL: begin
                busy_d = 1'b0;
                fail_d = 1'b1;
            end
`endif
            S_RD_SI: s_address_d = i_d;
            S_RD_SJ: s_address_d = j_d;
            S_WR_SI: begin
                s_address_d = i_d;
                s_data_d    = sj_d;
                s_wren_d    = 1'b1;
                s_rden_d    = 1'b0;
            end
            S_WR_SJ: begin
                s_address_d = j_d;
                s_data_d    = si_d;
                s_wren_d    = 1'b1;
                s_rden_d    = 1'b0;
            end
            S_RD_F: begin
                s_address_d   = si_d + sj_d;
                msg_address_d = k_d;
            end
            S_WR_DEC: begin
                dec_address_d = k_d;
                dec_data_d    = f_d ^ enc_d;
                dec_wren_d    = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i_q           <= '0;
            j_q           <= '0;
            k_q           <= '0;
            si_q          <= '0;
            sj_q          <= '0;
            f_q           <= '0;
            enc_q         <= '0;
            stop_pend_q   <= 1'b0;
            s_address_q   <= '0;
            s_data_q      <= '0;
            s_wren_q      <= 1'b0;
            s_rden_q      <= 1'b1;
            msg_address_q <= '0;
            dec_address_q <= '0;
            dec_data_q    <= '0;
            dec_wren_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            fail_q        <= 1'b0;
        end else begin
            i_q           <= i_d;
            j_q           <= j_d;
            k_q           <= k_d;
            si_q          <= si_d;
            sj_q          <= sj_d;
            f_q           <= f_d;
            enc_q         <= enc_d;
            stop_pend_q   <= stop_pend_d;
            s_address_q   <= s_address_d;
            s_data_q      <= s_data_d;
            s_wren_q      <= s_wren_d;
            s_rden_q      <= s_rden_d;
            msg_address_q <= msg_address_d;
            dec_address_q <= dec_address_d;
            dec_data_q    <= dec_data_d;
            dec_wren_q    <= dec_wren_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            fail_q        <= fail_d;
        end
    end

    assign s_address   = s_address_q;
    assign s_data      = s_data_q;
    assign s_wren      = s_wren_q;
    assign s_rden      = s_rden_q;
    assign msg_address = msg_address_q;
    assign dec_address = dec_address_q;
    assign dec_data    = dec_data_q;
    assign dec_wren    = dec_wren_q;
    assign busy        = busy_q;
    assign done        = done_q;
`ifdef CHAR_CHECK_EN
    assign fail        = fail_q;
`else
    assign fail        = 1'b0;
`endif

endmodule

// File: tb/tb_prga_decrypt_fsm.sv
// Bench for prga_decrypt_fsm: instance 0 (MSG_LEN=32) and instance 1 (MSG_LEN=256),
// each with its own S RAM / message ROM / decrypted RAM models of 2-clock read latency.
module tb_prga_decrypt_fsm;

    localparam int unsigned RD_LAT = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] start, stop, load;
    logic [1:0] busy, done, fail;
    logic [7:0] enc_src [256];
    logic [7:0] pt [256];
    logic [7:0] ks [256];
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int unsigned LEN = (g == 0) ? 32 : 256;
        logic [7:0] s_q, s_address, s_data, msg_address, msg_q, dec_address, dec_data;
        logic       s_wren, s_rden, dec_wren;
        logic [7:0] s_mem [256];
        logic [7:0] dec_mem [256];
        logic [7:0] s_pipe, m_pipe;
        int         dec_cnt = 0;
        int         ord_err = 0;
        int         hz_err  = 0;

        prga_decrypt_fsm #(.MSG_LEN(LEN), .RD_LAT(RD_LAT)) u_dut (
            .clk         (clk),
            .reset       (reset),
            .start       (start[g]),
            .stop        (stop[g]),
            .s_q         (s_q),
            .s_address   (s_address),
            .s_data      (s_data),
            .s_wren      (s_wren),
            .s_rden      (s_rden),
            .msg_address (msg_address),
            .msg_q       (msg_q),
            .dec_address (dec_address),
            .dec_data    (dec_data),
            .dec_wren    (dec_wren),
            .busy        (busy[g]),
            .done        (done[g]),
            .fail        (fail[g])
        );

        // Memory models: identity preload on load, two-stage read pipelines
        always @(posedge clk) begin
            if (load[g]) begin
                for (int a = 0; a < 256; a++) begin
                    s_mem[a]   <= 8'(a);
                    dec_mem[a] <= 8'hEE;
                end
                dec_cnt <= 0;
            end else begin
                if (s_wren) s_mem[s_address] <= s_data;
                if (dec_wren) begin
                    dec_mem[dec_address] <= dec_data;
                    if (dec_address != 8'(dec_cnt)) ord_err <= ord_err + 1;
                    dec_cnt <= dec_cnt + 1;
                end
                if (s_wren && (dec_wren || s_rden)) hz_err <= hz_err + 1;
            end
            s_pipe <= s_mem[s_address];
            s_q    <= s_pipe;
            m_pipe <= enc_src[msg_address];
            msg_q  <= m_pipe;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Textbook RC4 PRGA from an identity S array
    task automatic gen_ks(input int n);
        int s [256];
        int i, j, t;
        i = 0;
        j = 0;
        for (int a = 0; a < 256; a++) s[a] = a;
        for (int k = 0; k < n; k++) begin
            i = (i + 1) % 256;
            j = (j + s[i]) % 256;
            t = s[i];
            s[i] = s[j];
            s[j] = t;
            ks[k] = 8'(s[(s[i] + s[j]) % 256]);
        end
    endtask

    // Random lowercase/space plaintext, encrypted with the model keystream
    task automatic set_msg(input int n);
        int r;
        gen_ks(n);
        for (int k = 0; k < 256; k++) begin
            r = $urandom_range(0, 26);
            pt[k] = (r == 26) ? 8'h20 : 8'(32'h61 + r);
            enc_src[k] = (k < n) ? (pt[k] ^ ks[k]) : 8'h00;
        end
    endtask

    task automatic pulse_start(input int g);
        start[g] = 1'b1;
        @(negedge clk);
        start[g] = 1'b0;
    endtask

    task automatic pulse_load(input int g);
        load[g] = 1'b1;
        @(negedge clk);
        load[g] = 1'b0;
    endtask

    task automatic check_msg0(input string tag);
        for (int k = 0; k < 32; k++)
            check($sformatf("%s[%0d]", tag, k), 32'(g_inst[0].dec_mem[k]), 32'(pt[k]));
    endtask

    initial begin
        reset = 1'b1;
        start = '0;
        stop  = '0;
        load  = 2'b11;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_s_rden", 32'(g_inst[0].s_rden), 32'd1);
        check("rst_s_wren", 32'(g_inst[0].s_wren), 32'd0);
        check("rst_s_address", 32'(g_inst[0].s_address), 32'd0);
        check("rst_dec_wren", 32'(g_inst[0].dec_wren), 32'd0);
        check("rst_busy_done", 32'({busy[0], done[0], fail[0]}), 32'd0);
        reset = 1'b0;
        load  = 2'b00;
        @(negedge clk);

        // Identity S: first two bytes and swap result, then the full 32-byte message
        set_msg(32);
        pt[0] = 8'h61;
        pt[1] = 8'h62;
        enc_src[0] = 8'h63;
        enc_src[1] = 8'h67;
        pulse_start(0);
        check("busy_after_start", 32'(busy[0]), 32'd1);
        for (int n = 0; n < 2000 && g_inst[0].dec_cnt < 2; n++) @(negedge clk);
        check("t1_two_bytes", 32'(g_inst[0].dec_cnt), 32'd2);
        check("t1_dec0", 32'(g_inst[0].dec_mem[0]), 32'h61);
        check("t1_dec1", 32'(g_inst[0].dec_mem[1]), 32'h62);
        check("t1_S2", 32'(g_inst[0].s_mem[2]), 32'd3);
        check("t1_S3", 32'(g_inst[0].s_mem[3]), 32'd2);
        for (int n = 0; n < 2000 && !done[0]; n++) @(negedge clk);
        check("t2_done", 32'({done[0], busy[0], fail[0]}), 32'b100);
        check("t2_wren_count", 32'(g_inst[0].dec_cnt), 32'd32);
        check_msg0("t2_dec");

        // Stop during RD_SJ of byte 5: byte 5 completes, nothing after
        pulse_load(0);
        set_msg(32);
        pulse_start(0);
        for (int n = 0; n < 2000 && g_inst[0].dec_cnt < 5; n++) @(negedge clk);
        repeat (4) @(negedge clk);
        stop[0] = 1'b1;
        @(negedge clk);
        stop[0] = 1'b0;
        for (int n = 0; n < 200 && busy[0]; n++) @(negedge clk);
        repeat (20) @(negedge clk);
        check("t3_idle", 32'({busy[0], done[0]}), 32'd0);
        check("t3_wren_count", 32'(g_inst[0].dec_cnt), 32'd6);
        check("t3_dec5", 32'(g_inst[0].dec_mem[5]), 32'(pt[5]));
        check("t3_dec6_untouched", 32'(g_inst[0].dec_mem[6]), 32'hEE);

        // Reset while writing S, then a clean restart from k=0
        pulse_load(0);
        set_msg(32);
        pulse_start(0);
        for (int n = 0; n < 200 && !g_inst[0].s_wren; n++) @(negedge clk);
        check("t4_in_write", 32'(g_inst[0].s_wren), 32'd1);
        reset = 1'b1;
        #1;
        check("t4_rst_s_wren", 32'(g_inst[0].s_wren), 32'd0);
        check("t4_rst_s_rden", 32'(g_inst[0].s_rden), 32'd1);
        check("t4_rst_s_addr_data", 32'({g_inst[0].s_address, g_inst[0].s_data}), 32'd0);
        check("t4_rst_busy", 32'(busy[0]), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        pulse_load(0);
        pulse_start(0);
        for (int n = 0; n < 2000 && !done[0]; n++) @(negedge clk);
        check("t4_done", 32'(done[0]), 32'd1);
        check("t4_wren_count", 32'(g_inst[0].dec_cnt), 32'd32);
        check_msg0("t4_dec");

`ifdef CHAR_CHECK_EN
        // Out-of-range plaintext at byte 3 aborts into FAIL after writing it
        pulse_load(0);
        set_msg(32);
        pt[3] = 8'h41;
        enc_src[3] = pt[3] ^ ks[3];
        pulse_start(0);
        for (int n = 0; n < 2000 && !(done[0] || fail[0]); n++) @(negedge clk);
        repeat (20) @(negedge clk);
        check("t5_fail", 32'({fail[0], done[0], busy[0]}), 32'b100);
        check("t5_dec3", 32'(g_inst[0].dec_mem[3]), 32'h41);
        check("t5_wren_count", 32'(g_inst[0].dec_cnt), 32'd4);
        check("t5_dec4_untouched", 32'(g_inst[0].dec_mem[4]), 32'hEE);
`else
        check("t5_fail_tied", 32'(fail[0]), 32'd0);
`endif

        // 256-byte message: i wraps, start during busy ignored
        pulse_load(1);
        set_msg(256);
        pulse_start(1);
        repeat (300) @(negedge clk);
        check("t6_busy_mid", 32'(busy[1]), 32'd1);
        pulse_start(1);
        for (int n = 0; n < 10000 && !done[1]; n++) @(negedge clk);
        check("t6_done", 32'({done[1], busy[1], fail[1]}), 32'b100);
        check("t6_wren_count", 32'(g_inst[1].dec_cnt), 32'd256);
        for (int k = 0; k < 256; k++)
            check($sformatf("t6_dec[%0d]", k), 32'(g_inst[1].dec_mem[k]), 32'(pt[k]));

        check("order0", 32'(g_inst[0].ord_err), 32'd0);
        check("order1", 32'(g_inst[1].ord_err), 32'd0);
        check("hazard0", 32'(g_inst[0].hz_err), 32'd0);
        check("hazard1", 32'(g_inst[1].hz_err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
